// File: rtl/datapath_control_sequencer.sv
// Multi-cycle LEGv8-subset control sequencer: latches one instruction per handshake,
// drives the datapath control word for one (or two, for LDUR) cycles and owns the PC.
module datapath_control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    input  logic [3:0]  status,
    output logic [4:0]  DA,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic        W,
    output logic [63:0] K,
    output logic        BS,
    output logic [4:0]  FS,
    output logic        write,
    output logic        selEN,
    output logic [63:0] pc,
    output logic        illegal,
    output logic [1:0]  dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE and the source holds instruction until then.
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, LOAD = 2'd2} state_t;

    localparam logic [4:0] FS_PASSB = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_XOR   = 5'b01100;
    localparam logic [4:0] FS_SHL   = 5'b10000;

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic [63:0] pc_nxt;

    logic [4:0]  rd, rn, rm;
    logic [63:0] k_addi, k_lsl, k_movz, k_mem, off_cbz, off_b;
    logic        is_add, is_eor, is_addi, is_lsl, is_movz, is_stur, is_ldur, is_cbz, is_b;
    logic        unused_status;

    assign rd = ir[4:0];
    assign rn = ir[9:5];
    assign rm = ir[20:16];

    assign k_addi  = {52'd0, ir[21:10]};
    assign k_lsl   = {58'd0, ir[15:10]};
    assign k_movz  = {48'd0, ir[20:5]};
    assign k_mem   = {{55{ir[20]}}, ir[20:12]};
    assign off_cbz = {{43{ir[23]}}, ir[23:5], 2'b00};
    assign off_b   = {{36{ir[25]}}, ir[25:0], 2'b00};

    assign is_add  = (ir[31:21] == 11'b10001011000);
    assign is_eor  = (ir[31:21] == 11'b11001010000);
    assign is_addi = (ir[31:22] == 10'b1001000100);
    assign is_lsl  = (ir[31:21] == 11'b11010011011);
    assign is_movz = (ir[31:23] == 9'b110100101);
    assign is_stur = (ir[31:21] == 11'b11111000000);
    assign is_ldur = (ir[31:21] == 11'b11111000010);
    assign is_cbz  = (ir[31:24] == 8'b10110100);
    assign is_b    = (ir[31:26] == 6'b000101);

    // Only Z takes part in sequencing; the other flags are carried for future branch types.
    assign unused_status = ^status[3:1];

    assign instr_ready = (state == IDLE) && reset;
    assign dbg_state   = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ir    <= 32'd0;
            pc    <= 64'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == IDLE && instr_valid)
                ir <= instruction;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        DA        = 5'd0;
        SA        = 5'd0;
        SB        = 5'd0;
        W         = 1'b0;
        K         = 64'd0;
        BS        = 1'b0;
        FS        = FS_PASSB;
        write     = 1'b0;
        selEN     = 1'b1;
        illegal   = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid)
                    state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = IDLE;
                pc_nxt    = pc + 64'd4;
                if (is_add || is_eor) begin
                    DA = rd;
                    SA = rn;
                    SB = rm;
                    FS = is_add ? FS_ADD : FS_XOR;
                    W  = 1'b1;
                end else if (is_addi) begin
                    DA = rd;
                    SA = rn;
                    K  = k_addi;
                    BS = 1'b1;
                    FS = FS_ADD;
                    W  = 1'b1;
                end else if (is_lsl) begin
                    DA = rd;
                    SA = rn;
                    K  = k_lsl;
                    BS = 1'b1;
                    FS = FS_SHL;
                    W  = 1'b1;
                end else if (is_movz) begin
                    DA = rd;
                    SA = 5'd31;
                    K  = k_movz;
                    BS = 1'b1;
                    W  = 1'b1;
                end else if (is_stur) begin
                    SA    = rn;
                    SB    = rd;
                    K     = k_mem;
                    BS    = 1'b1;
                    FS    = FS_ADD;
                    write = 1'b1;
                end else if (is_ldur) begin
                    // PC advances when the LOAD cycle closes, not here.
                    SA        = rn;
                    K         = k_mem;
                    BS        = 1'b1;
                    FS        = FS_ADD;
                    selEN     = 1'b0;
                    state_nxt = LOAD;
                    pc_nxt    = pc;
                end else if (is_cbz) begin
                    SB = rd;
                    if (status[0])
                        pc_nxt = pc + off_cbz;
                end else if (is_b) begin
                    pc_nxt = pc + off_b;
                end else begin
                    illegal = 1'b1;
                end
            end
            LOAD: begin
                DA        = rd;
                SA        = rn;
                K         = k_mem;
                BS        = 1'b1;
                FS        = FS_ADD;
                selEN     = 1'b0;
                W         = 1'b1;
                state_nxt = IDLE;
                pc_nxt    = pc + 64'd4;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_control_sequencer.sv
// Bench for datapath_control_sequencer: directed instructions, expected control words
// queued by the driver and popped by a monitor on every busy (non-IDLE) cycle.
module tb_datapath_control_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [3:0]  status;
    logic [4:0]  DA, SA, SB;
    logic        W;
    logic [63:0] K;
    logic        BS;
    logic [4:0]  FS;
    logic        write;
    logic        selEN;
    logic [63:0] pc;
    logic        illegal;
    logic [1:0]  dbg_state;

    typedef struct packed {
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        w;
        logic [63:0] k;
        logic        bs;
        logic [4:0]  fs;
        logic        wr;
        logic        sel;
        logic        ill;
        logic [63:0] pc;
    } ctl_t;
    localparam int CTL_W = $bits(ctl_t);

    logic [CTL_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    datapath_control_sequencer dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .status(status), .DA(DA), .SA(SA), .SB(SB), .W(W), .K(K),
        .BS(BS), .FS(FS), .write(write), .selEN(selEN), .pc(pc), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog state=%0d exp 0", dbg_state);
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [CTL_W-1:0] got,
                                  input logic [CTL_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endfunction

    function automatic logic [CTL_W-1:0] mk(input logic [4:0] da, input logic [4:0] sa,
        input logic [4:0] sb, input logic w, input logic [63:0] k, input logic bs,
        input logic [4:0] fs, input logic wr, input logic sel, input logic ill,
        input logic [63:0] p);
        ctl_t c;
        c = '{da: da, sa: sa, sb: sb, w: w, k: k, bs: bs, fs: fs, wr: wr, sel: sel, ill: ill, pc: p};
        return c;
    endfunction

    // scoreboard monitor
    always @(negedge clock) begin
        if (reset && !instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_busy state %0d exp idle", dbg_state);
            end else begin
                check("ctl", {DA, SA, SB, W, K, BS, FS, write, selEN, illegal, pc}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic issue(input logic [31:0] ins);
        int n = 0;
        while (!instr_ready && n < 50) begin
            @(posedge clock);
            #1 n++;
        end
        if (n >= 50) check("ready_timeout", {152'd0, instr_ready}, {152'd0, 1'b1});
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instruction = 32'hDEAD_BEEF;
    endtask

    task automatic wait_idle_pc(input logic [63:0] exp_pc);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clock);
            #1 n++;
        end
        if (n >= 20) check("idle_timeout", {152'd0, instr_ready}, {152'd0, 1'b1});
        check("pc", {89'd0, pc}, {89'd0, exp_pc});
    endtask

    task automatic idle_chk(input logic [63:0] exp_pc);
        @(negedge clock);
        check("idle", {79'd0, instr_ready, W, write, selEN, FS, illegal, pc},
                      {79'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0, exp_pc});
    endtask

    localparam logic [63:0] KM8 = 64'hFFFF_FFFF_FFFF_FFF8;

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'd0;
        status      = 4'd0;
        @(negedge clock);
        check("in_reset", {79'd0, instr_ready, W, write, selEN, FS, illegal, pc},
                          {79'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0, 64'd0});
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) idle_chk(64'd0);

        // MOVZ X5,#24 ; ADD X1,X5,X7
        exp_q.push_back(mk(5'd5, 5'd31, 5'd0, 1'b1, 64'd24, 1'b1, 5'b00100, 1'b0, 1'b1, 1'b0, 64'd0));
        issue(32'hD280_0305);
        wait_idle_pc(64'd4);
        exp_q.push_back(mk(5'd1, 5'd5, 5'd7, 1'b1, 64'd0, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0, 64'd4));
        issue(32'h8B07_00A1);
        wait_idle_pc(64'd8);
        // EOR X2,X3,X4
        exp_q.push_back(mk(5'd2, 5'd3, 5'd4, 1'b1, 64'd0, 1'b0, 5'b01100, 1'b0, 1'b1, 1'b0, 64'd8));
        issue(32'hCA04_0062);
        wait_idle_pc(64'd12);
        // ADDI X9,X10,#100
        exp_q.push_back(mk(5'd9, 5'd10, 5'd0, 1'b1, 64'd100, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0, 64'd12));
        issue(32'h9101_9149);
        wait_idle_pc(64'd16);
        // LSL X4,X6,#3
        exp_q.push_back(mk(5'd4, 5'd6, 5'd0, 1'b1, 64'd3, 1'b1, 5'b10000, 1'b0, 1'b1, 1'b0, 64'd16));
        issue(32'hD360_0CC4);
        wait_idle_pc(64'd20);
        // LDUR X0,[X7,#-8]: EXEC then LOAD
        exp_q.push_back(mk(5'd0, 5'd7, 5'd0, 1'b0, KM8, 1'b1, 5'b01000, 1'b0, 1'b0, 1'b0, 64'd20));
        exp_q.push_back(mk(5'd0, 5'd7, 5'd0, 1'b1, KM8, 1'b1, 5'b01000, 1'b0, 1'b0, 1'b0, 64'd20));
        issue(32'hF85F_80E0);
        wait_idle_pc(64'd24);
        // STUR X17,[X7,#0]
        exp_q.push_back(mk(5'd0, 5'd7, 5'd17, 1'b0, 64'd0, 1'b1, 5'b01000, 1'b1, 1'b1, 1'b0, 64'd24));
        issue(32'hF800_00F1);
        wait_idle_pc(64'd28);
        // all-zero word is unsupported
        exp_q.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'b00100, 1'b0, 1'b1, 1'b1, 64'd28));
        issue(32'h0000_0000);
        wait_idle_pc(64'd32);
        idle_chk(64'd32);

        // CBZ X3,#+4 taken
        do_reset();
        status = 4'b0001;
        exp_q.push_back(mk(5'd0, 5'd0, 5'd3, 1'b0, 64'd0, 1'b0, 5'b00100, 1'b0, 1'b1, 1'b0, 64'd0));
        issue(32'hB400_0083);
        wait_idle_pc(64'd16);
        // CBZ not taken, then Z rising late in EXEC makes it taken
        do_reset();
        status = 4'b0000;
        exp_q.push_back(mk(5'd0, 5'd0, 5'd3, 1'b0, 64'd0, 1'b0, 5'b00100, 1'b0, 1'b1, 1'b0, 64'd0));
        issue(32'hB400_0083);
        wait_idle_pc(64'd4);
        exp_q.push_back(mk(5'd0, 5'd0, 5'd3, 1'b0, 64'd0, 1'b0, 5'b00100, 1'b0, 1'b1, 1'b0, 64'd4));
        issue(32'hB400_0083);
        #6 status = 4'b0001;
        wait_idle_pc(64'd20);
        status = 4'b0000;
        // B #-1 wraps below zero
        do_reset();
        exp_q.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'b00100, 1'b0, 1'b1, 1'b0, 64'd0));
        issue(32'h17FF_FFFF);
        wait_idle_pc(64'hFFFF_FFFF_FFFF_FFFC);

        // reset asserted in the middle of LOAD
        do_reset();
        exp_q.push_back(mk(5'd0, 5'd7, 5'd0, 1'b0, KM8, 1'b1, 5'b01000, 1'b0, 1'b0, 1'b0, 64'd0));
        issue(32'hF85F_80E0);
        @(posedge clock);
        #2;
        check("load_w", {152'd0, W}, {152'd0, 1'b1});
        reset = 1'b0;
        #1;
        check("abort", {87'd0, W, write, pc}, {87'd0, 1'b0, 1'b0, 64'd0});
        @(posedge clock);
        #1 reset = 1'b1;
        idle_chk(64'd0);
        idle_chk(64'd0);

        check("q_empty", CTL_W'(exp_q.size()), CTL_W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_control_sequencer.md
# datapath_control_sequencer

Multi-cycle control unit sitting directly upstream of the register-file/ALU/memory datapath. Accepts one 32-bit LEGv8-subset instruction per handshake, decodes it, and drives the datapath control word (DA, SA, SB, W, K, BS, FS, write, selEN) for one or two cycles. Maintains the 64-bit program counter, updated from datapath status for conditional branches. Unsupported encodings are flagged without touching architectural state.

## Interface
- No parameters; all widths fixed by the datapath control word.
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; state forced while low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept; high only in IDLE
- instruction  in  32  instruction word, sampled on valid&&ready
- status  in  4  datapath flags {V,C,N,Z}; Z = status[0]
- DA, SA, SB  out  5 each  dest / A-source / B-source register
- W  out  1  register-file write enable
- K  out  64  constant to datapath B-mux
- BS  out  1  B-select: 1 = K, 0 = register SB
- FS  out  5  ALU function: 00100 pass-B, 01000 add, 01100 xor, 10000 shift-left
- write  out  1  data-memory write enable
- selEN  out  1  result select: 1 = ALU, 0 = memory
- pc  out  64  program counter
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- States: IDLE, EXEC, LOAD.
- IDLE: instr_ready=1; on instr_valid, latch instruction into IR, go EXEC. Otherwise hold.
- EXEC: control word decoded from IR (fields Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16]):
  - ADD (IR[31:21]=10001011000): DA=Rd SA=Rn SB=Rm BS=0 FS=01000 W=1.
  - EOR (11001010000): as ADD with FS=01100.
  - ADDI (IR[31:22]=1001000100): DA=Rd SA=Rn K=zext(IR[21:10]) BS=1 FS=01000 W=1.
  - LSL (11010011011): DA=Rd SA=Rn K=zext(IR[15:10]) BS=1 FS=10000 W=1.
  - MOVZ (IR[31:23]=110100101): DA=Rd SA=31 K=zext(IR[20:5]) BS=1 FS=00100 W=1; hw field ignored.
  - STUR (11111000000): SA=Rn SB=Rt K=sext(IR[20:12]) BS=1 FS=01000 write=1 W=0.
  - LDUR (11111000010): SA=Rn K=sext(IR[20:12]) BS=1 FS=01000 selEN=0 W=0; go LOAD.
  - CBZ (IR[31:24]=10110100): SB=Rt BS=0 FS=00100 W=0; branch taken iff Z=1 at end of cycle.
  - B (IR[31:26]=000101): W=0 write=0; always taken.
  - Anything else: illegal=1, W=0, write=0, pc+=4.
- LOAD: same address control word as LDUR EXEC, plus DA=Rt W=1 selEN=0; returns to IDLE.
- Default (IDLE, and any field not listed): DA=SA=SB=0, K=0, BS=0, FS=00100, W=0, write=0, selEN=1.
- PC: updated at the final cycle of each instruction (EXEC, or LOAD for LDUR). Not-taken/non-branch: pc+4. Taken CBZ: pc+(sext(IR[23:5])<<2). B: pc+(sext(IR[25:0])<<2). All arithmetic modulo 2^64; wrap-around silent.

## Timing
- Reset low: state=IDLE, IR=0, pc=0, illegal=0, control outputs at default, instr_ready=1 once reset released.
- Latency: accept edge -> EXEC next cycle. Single-cycle ops: back in IDLE one cycle later (2 cycles per instruction incl. IDLE). LDUR: 3 cycles.
- Control outputs are registered-state decodes: stable for the whole EXEC/LOAD cycle; datapath writes on the edge closing that cycle.
- instr_valid ignored outside IDLE; instruction must be held by the source until accepted.
- CBZ samples status combinationally during EXEC; only the value at the closing edge matters.
- Reset asserted mid-EXEC or mid-LOAD: immediate abort, no PC update, W/write forced 0 asynchronously.

## Test plan
- Reset release, no valid -> instr_ready=1, pc=0, W=0, write=0, selEN=1, FS=00100 held over 5 cycles.
- MOVZ X5,#24 then ADD X1,X5,X7 -> EXEC cycles show DA=5 SA=31 K=24 BS=1 FS=00100 W=1, then DA=1 SA=5 SB=7 BS=0 FS=01000 W=1; pc=8.
- LDUR X0,[X7,#-8] -> EXEC: SA=7 K=64'hFFFF_FFFF_FFFF_FFF8 selEN=0 W=0; LOAD: DA=0 W=1; instr_ready low 2 cycles; pc=4.
- STUR X17,[X7,#0] -> one EXEC cycle write=1 W=0 SB=17; pc=4.
- CBZ X3,#+4 with status=4'b0001 -> pc=16; repeat from pc=0 with status=4'b0000 -> pc=4. B #-1 from pc=0 -> pc=64'hFFFF_FFFF_FFFF_FFFC.
- Instruction 32'h0 -> illegal pulse 1 cycle, W=0, write=0, pc+4; reset asserted mid-LOAD -> W=0 immediately, pc unchanged, IDLE after release.
